// File: rtl/str_table_reader.sv
// str_table_reader: walks the packed 16-entry string table on each frame start and
// streams one glyph request per beat. Define STR_SKIP_SPACE_EN to suppress space beats.
`ifndef LETTER_PIXEL_WIDTH
`define LETTER_PIXEL_WIDTH 8
`endif

module str_table_reader #(
  parameter int unsigned L_W   = `LETTER_PIXEL_WIDTH,
  parameter int unsigned N_ENT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_ENT*256-1:0] i_str,
  input  logic                 i_start,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [7:0]           o_char,
  output logic [2:0]           o_color,
  output logic [11:0]          o_x,
  output logic [11:0]          o_y,
  output logic                 o_last,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned ENT_W    = 256;
  localparam int unsigned TBL_W    = N_ENT * ENT_W;
  localparam int unsigned IDX_W    = $clog2(N_ENT);
  localparam logic [IDX_W-1:0] LAST_ENT = IDX_W'(N_ENT - 1);
  localparam logic [7:0]   SPACE    = 8'h20;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] entry_idx;
  logic [3:0]       char_idx;
  logic [146:0]     entry_q;     // pad bits above colour are never stored

  logic [255:0]     cur_entry;
  logic             scan_empty;
  logic [3:0]       scan_idx;
  logic             next_ok;
  logic [3:0]       next_idx;
  logic [3:0]       beat_idx;
  logic             beat_more;
  logic [7:0]       beat_char;
  logic [11:0]      beat_x;
  logic             unused_pad;

  function automatic logic [7:0] char_at(input logic [127:0] chars, input logic [3:0] idx);
    logic [7:0] c;
    c = 8'h00;
    for (int j = 0; j < 16; j++)
      if (idx == 4'(j)) c = chars[127-8*j -: 8];
    return c;
  endfunction

`ifdef STR_SKIP_SPACE_EN
  // Lowest non-space index >= lo; descending scan so the lowest match wins.
  function automatic logic [4:0] find_from(input logic [127:0] chars, input logic [4:0] lo);
    logic [4:0] res;
    res = 5'd0;
    for (int j = 15; j >= 0; j--)
      if (5'(j) >= lo && chars[127-8*j -: 8] != SPACE) res = {1'b1, 4'(j)};
    return res;
  endfunction

  function automatic logic any_from(input logic [127:0] chars, input logic [4:0] lo);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < 16; j++)
      if (5'(j) >= lo && chars[127-8*j -: 8] != SPACE) hit = 1'b1;
    return hit;
  endfunction
`endif

  // Select the entry addressed by entry_idx; entry 0 sits in the MSBs.
  always_comb begin
    cur_entry = '0;
    for (int k = 0; k < N_ENT; k++)
      if (entry_idx == IDX_W'(k)) cur_entry = i_str[TBL_W-1-ENT_W*k -: ENT_W];
  end

  assign unused_pad = ^cur_entry[255:147];

  always_comb begin
`ifdef STR_SKIP_SPACE_EN
    logic [4:0] srch_scan;
    logic [4:0] srch_next;
    srch_scan  = find_from(cur_entry[127:0], 5'd0);
    srch_next  = find_from(entry_q[127:0], {1'b0, char_idx} + 5'd1);
    scan_empty = !srch_scan[4];
    scan_idx   = srch_scan[3:0];
    next_ok    = srch_next[4];
    next_idx   = srch_next[3:0];
    beat_idx   = o_valid ? next_idx : char_idx;
    beat_more  = any_from(entry_q[127:0], {1'b0, beat_idx} + 5'd1);
`else
    scan_empty = (cur_entry[127:0] == {16{SPACE}});
    scan_idx   = 4'd0;
    next_ok    = (char_idx != 4'd15);
    next_idx   = char_idx + 4'd1;
    beat_idx   = o_valid ? next_idx : char_idx;
    beat_more  = (beat_idx != 4'd15);
`endif
    beat_char  = char_at(entry_q[127:0], beat_idx);
    beat_x     = 12'(entry_q[143:136]) + 12'(beat_idx) * 12'(L_W);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      entry_idx <= '0;
      char_idx  <= '0;
      entry_q   <= '0;
      o_valid   <= 1'b0;
      o_char    <= '0;
      o_color   <= '0;
      o_x       <= '0;
      o_y       <= '0;
      o_last    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= SCAN;
            entry_idx <= '0;
            o_busy    <= 1'b1;
          end
        end
        SCAN: begin
          entry_q <= cur_entry[146:0];
          if (!scan_empty) begin
            char_idx <= scan_idx;
            state    <= EMIT;
          end else if (entry_idx == LAST_ENT) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            entry_idx <= entry_idx + IDX_W'(1);
          end
        end
        EMIT: begin
          // First beat of the entry loads from the latched copy; accepted beats chain back-to-back.
          if (!o_valid || (i_ready && next_ok)) begin
            char_idx <= beat_idx;
            o_valid  <= 1'b1;
            o_char   <= beat_char;
            o_color  <= entry_q[146:144];
            o_x      <= beat_x;
            o_y      <= {4'b0, entry_q[135:128]};
            o_last   <= !beat_more;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            if (entry_idx == LAST_ENT) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              entry_idx <= entry_idx + IDX_W'(1);
              state     <= SCAN;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
